unlock_seq_tx: RTL and testbench
================================

# unlock_seq_tx

Transmit side of the byte-sequence unlock protocol. On a start request it drives the three-byte key (0x1F, 0xB2, 0x3C) onto an 8-bit bus on consecutive cycles. It then watches the lock's `unlocked` flag for confirmation and reports `done` or `fail`. It sits in front of the sequence-detector lock and is the stimulus source for the lock in system-level concolic runs.

## Interface
Parameters:
- `KEY0`, default 8'h1F: first key byte.
- `KEY1`, default 8'hB2: second key byte.
- `KEY2`, default 8'h3C: third key byte.
- `TIMEOUT`, default 4: WAIT-state cycles allowed for `unlocked` to rise, range 1..255.
- `MAX_RETRY`, default 2: extra attempts after the first timeout, range 0..15. Used only with `UNLOCK_TX_RETRY_EN`.

Ports:
- `clock`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request an unlock attempt. Sampled only in IDLE.
- `abort`, in, 1: cancel the operation in progress. Highest priority after `reset`.
- `unlocked`, in, 1: `out` flag from the lock.
- `byte_out`, out, 8: key byte bus, registered.
- `byte_valid`, out, 1: high while `byte_out` carries a key byte.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse; lock confirmed open.
- `fail`, out, 1: one-cycle pulse; all attempts timed out.
- `attempts`, out, 4: number of attempts started in the current or last operation, saturating at 15.

## Operation
- States: IDLE, SEND0, SEND1, SEND2, WAIT.
- **Reset:** `byte_out`=8'h00, `byte_valid`=0, `busy`=0, `done`=0, `fail`=0, `attempts`=0, state IDLE. Reset mid-operation has the same effect on the next edge; no pulse is emitted.
- **IDLE**
  - `start`=1 and `unlocked`=0: go to SEND0, set `attempts`=1.
  - `start`=1 and `unlocked`=1: stay in IDLE, emit a `done` pulse, emit no bytes, leave `attempts` unchanged.
- **SEND0/1/2:** drive KEY0/KEY1/KEY2 with `byte_valid`=1 on three back-to-back cycles. No gaps are allowed, because the lock drops to its idle state on any non-matching byte. SEND2 always goes to WAIT, and the timeout counter clears.
- **Outside SEND states:** `byte_out` is 8'h00 and `byte_valid`=0. 8'h00 is not a key byte and must not be changed.
- **WAIT:** the counter increments every cycle.
  - `unlocked`=1 sampled: go to IDLE and emit `done`. `unlocked` takes priority over the timeout on the same edge.
  - Counter reaches TIMEOUT with `unlocked`=0: handled as a timeout (see Configuration).
- **abort:** in any non-IDLE state, go to IDLE next edge, `byte_out`=8'h00, no `done` or `fail`. `abort` wins over `start` and `unlocked` on the same edge. `abort` in IDLE is a no-op.
- **start while busy:** ignored, not queued.
- `done` and `fail` are never high together, and never high for two consecutive cycles.

## Timing
- `start` sampled at edge k: KEY0 on `byte_out` during cycle k+1, KEY1 during k+2, KEY2 during k+3, `busy`=1 from k+1.
- The lock registers KEY2 at the end of k+3 and asserts `unlocked` during k+4, which is the first WAIT cycle.
- A fast lock gives `done` during k+5, with `busy`=0 in the same cycle.
- Timeout: with `unlocked` low, the timeout is declared at the TIMEOUT-th WAIT edge. The following cycle is either SEND0 (retry) or `fail`=1 (IDLE).
- Retry adds 3 + TIMEOUT cycles per attempt.
- Worst-case `busy` length: (1 + MAX_RETRY) × (3 + TIMEOUT) cycles.

## Configuration
- Macro: `UNLOCK_TX_RETRY_EN`.
- **Defined:** on timeout, if `attempts` < 1 + MAX_RETRY, return to SEND0 and increment `attempts`. Otherwise go to IDLE and pulse `fail`.
- **Undefined:** the first timeout goes to IDLE and pulses `fail`. MAX_RETRY is ignored, and `attempts` is never greater than 1.

## Test plan
- Reset, then `start` at edge 0 with a connected lock:
  - bytes 1F, B2, 3C in cycles 1–3;
  - `unlocked` high in cycle 4;
  - `done` in cycle 5;
  - `attempts`=1.
- `unlocked` tied 0, TIMEOUT=4, MAX_RETRY=2, macro defined:
  - three 7-cycle attempts;
  - `fail` at cycle 22;
  - `attempts`=3.
- Same stimulus with the macro undefined: one attempt, `fail` at cycle 8, `attempts`=1.
- `abort` during SEND1 (cycle 2):
  - `byte_out`=00 and `busy`=0 from cycle 3;
  - no `done` or `fail`;
  - the lock does not open.
- `start` with `unlocked` already 1: `done` next cycle, `byte_valid` never high.
- `reset` asserted in WAIT while `unlocked` rises on the same edge: all outputs 0 next cycle, no `done`. A `start` pulse at edge 3 while busy is ignored.

Source files
------------

// File: rtl/unlock_seq_tx.sv
// unlock_seq_tx: transmit side of the byte-sequence unlock protocol.
// Sends KEY0/KEY1/KEY2 on back-to-back cycles, then waits up to TIMEOUT
// cycles for the lock's `unlocked` flag and reports done or fail.
// Optional feature macro: UNLOCK_TX_RETRY_EN (retries up to MAX_RETRY
// extra attempts on timeout; default build fails on the first timeout).
module unlock_seq_tx #(
  parameter logic [7:0]  KEY0      = 8'h1F,
  parameter logic [7:0]  KEY1      = 8'hB2,
  parameter logic [7:0]  KEY2      = 8'h3C,
  parameter int unsigned TIMEOUT   = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       unlocked,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] attempts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND0,
    S_SEND1,
    S_SEND2,
    S_WAIT
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("unlock_seq_tx: TIMEOUT must be in 1..255");
  end
  if (MAX_RETRY > 15) begin : g_bad_retry
    $error("unlock_seq_tx: MAX_RETRY must be in 0..15");
  end

  // Last WAIT count value before the timeout edge.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
`ifdef UNLOCK_TX_RETRY_EN
  localparam logic [4:0] ATTEMPT_MAX = 5'(MAX_RETRY + 1);
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // One bit wider than the port so the retry limit still works once the
  // reported count has saturated at 15.
  logic [4:0] att_q, att_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (unlocked) begin
              // Already open: report it, but never on two cycles in a row.
              done_d = ~done_q;
            end else begin
              state_d = S_SEND0;
              att_d   = 5'd1;
            end
          end
        end
        S_SEND0: state_d = S_SEND1;
        S_SEND1: state_d = S_SEND2;
        S_SEND2: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (unlocked) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (cnt_q == WAIT_LAST) begin
`ifdef UNLOCK_TX_RETRY_EN
            if (att_q < ATTEMPT_MAX) begin
              state_d = S_SEND0;
              att_d   = att_q + 5'd1;
            end else begin
              state_d = S_IDLE;
              fail_d  = 1'b1;
            end
`else
            state_d = S_IDLE;
            fail_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    unique case (state_d)
      S_SEND0: byte_d = KEY0;
      S_SEND1: byte_d = KEY1;
      S_SEND2: byte_d = KEY2;
      default: byte_d = 8'h00;
    endcase
    valid_d = (state_d == S_SEND0) || (state_d == S_SEND1) || (state_d == S_SEND2);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      att_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign attempts   = att_q[4] ? 4'hF : att_q[3:0];

endmodule

// File: tb/tb_unlock_seq_tx.sv
// Self-checking bench for unlock_seq_tx: directed scenarios from the
// protocol description plus randomized stimulus against a cycle-position
// reference model. Works with or without UNLOCK_TX_RETRY_EN.
module tb_unlock_seq_tx;

  localparam int TO = 4;
  localparam int MR = 2;
`ifdef UNLOCK_TX_RETRY_EN
  localparam int MAX_TRIES = 1 + MR;
  localparam int FAILC     = 22;
  localparam bit RETRY     = 1'b1;
`else
  localparam int MAX_TRIES = 1;
  localparam int FAILC     = 8;
  localparam bit RETRY     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, abort = 1'b0, unlocked = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, busy, done, fail;
  logic [3:0] attempts;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] key [3];
  logic [7:0] hist [3];

  // Reference model: attempt position counted in cycles from SEND0.
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_tries  = 0;
  bit m_done   = 1'b0;
  bit m_fail   = 1'b0;

  always #5 clk = ~clk;

  unlock_seq_tx #(
    .TIMEOUT  (TO),
    .MAX_RETRY(MR)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .unlocked  (unlocked),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .attempts  (attempts)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit s, input bit a, input bit u, input bit r);
    bit nd = 1'b0;
    bit nf = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_tries  = 0;
    end else if (a && m_active) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        if (u) nd = !m_done;
        else begin
          m_active = 1'b1;
          m_pos    = 0;
          m_tries  = 1;
        end
      end
    end else if (m_pos < 3) begin
      m_pos++;
    end else if (u) begin
      m_active = 1'b0;
      nd       = 1'b1;
    end else if (m_pos - 2 == TO) begin
      if (m_tries < MAX_TRIES) begin
        m_pos = 0;
        m_tries++;
      end else begin
        m_active = 1'b0;
        nf       = 1'b1;
      end
    end else begin
      m_pos++;
    end
    m_done = nd;
    m_fail = nf;
  endtask

  // Apply inputs for the coming edge, advance one cycle, compare at negedge.
  task automatic step(input bit s, input bit a, input bit u, input bit r);
    logic [7:0] eb;
    bit         ev;
    start    = s;
    abort    = a;
    unlocked = u;
    reset    = r;
    model_edge(s, a, u, r);
    @(posedge clk);
    @(negedge clk);
    ev = m_active && (m_pos < 3);
    eb = ev ? key[m_pos] : 8'h00;
    chk("byte_out",   32'(byte_out),   32'(eb));
    chk("byte_valid", 32'(byte_valid), 32'(ev));
    chk("busy",       32'(busy),       32'(m_active));
    chk("done",       32'(done),       32'(m_done));
    chk("fail",       32'(fail),       32'(m_fail));
    chk("attempts",   32'(attempts),   32'((m_tries > 15) ? 15 : m_tries));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_byte",  32'(byte_out), 32'h0);
    chk("rst_busy",  32'(busy),     32'h0);
    chk("rst_att",   32'(attempts), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Behavioural lock: open during a cycle when the previous three bus bytes were the key.
  function automatic bit lock_open();
    return (hist[0] == key[0]) && (hist[1] == key[1]) && (hist[2] == key[2]);
  endfunction

  task automatic lock_push(input logic [7:0] b);
    hist[0] = hist[1];
    hist[1] = hist[2];
    hist[2] = b;
  endtask

  task automatic lock_clear();
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
  endtask

  initial begin
    bit u;
    key[0] = 8'h1F;
    key[1] = 8'hB2;
    key[2] = 8'h3C;
    lock_clear();
    @(negedge clk);

    // Connected lock: bytes in cycles 1-3, unlocked in 4, done in 5.
    do_reset();
    lock_clear();
    u = lock_open();
    lock_push(byte_out);
    step(1'b1, 1'b0, u, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      u = lock_open();
      if (c <= 3) chk("t1_byte", 32'(byte_out), 32'(key[c-1]));
      chk("t1_unlocked", 32'(u),    32'(c == 4));
      chk("t1_done",     32'(done), 32'(c == 5));
      chk("t1_busy",     32'(busy), 32'(c <= 4));
      lock_push(byte_out);
      step(1'b0, 1'b0, u, 1'b0);
    end
    chk("t1_attempts", 32'(attempts), 32'd1);

    // Lock never answers: timeout, with or without retries.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      chk("t2_fail", 32'(fail), 32'(c == FAILC));
      chk("t2_busy", 32'(busy), 32'(c < FAILC));
      if (RETRY && (c == 8 || c == 15)) chk("t2_retry_key0", 32'(byte_out), 32'h1F);
      if (c == FAILC) chk("t2_attempts", 32'(attempts), RETRY ? 32'd3 : 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Abort during SEND1: bus idle from cycle 3, no pulse, lock stays shut.
    do_reset();
    lock_clear();
    u = lock_open();
    lock_push(byte_out);
    step(1'b1, 1'b0, u, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      u = lock_open();
      chk("t3_unlocked", 32'(u), 32'h0);
      if (c >= 3) begin
        chk("t3_byte", 32'(byte_out), 32'h0);
        chk("t3_busy", 32'(busy),     32'h0);
      end
      chk("t3_done", 32'(done), 32'h0);
      chk("t3_fail", 32'(fail), 32'h0);
      lock_push(byte_out);
      step(1'b0, (c == 2), u, 1'b0);
    end

    // Start while already unlocked: immediate done, no bytes.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_done",     32'(done),       32'h1);
    chk("t4_valid",    32'(byte_valid), 32'h0);
    chk("t4_attempts", 32'(attempts),   32'd1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_valid_after", 32'(byte_valid), 32'h0);
      chk("t4_done_after",  32'(done),       32'h0);
    end

    // Start at edge 3 ignored; reset in WAIT beats unlocked.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_busy_wait",  32'(busy),       32'h1);
    chk("t5_valid_wait", 32'(byte_valid), 32'h0);
    chk("t5_att_wait",   32'(attempts),   32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_busy", 32'(busy),     32'h0);
    chk("t5_done", 32'(done),     32'h0);
    chk("t5_byte", 32'(byte_out), 32'h0);
    chk("t5_att",  32'(attempts), 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit rs, rr, ra, ru;
      rr = ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 29) == 0);
      ru = ($urandom_range(0, 5) == 0);
      step(rs, ra, ru, rr);
      if (done && fail) chk("done_fail_overlap", 32'h1, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
